imm_gen_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the decode stage. Extracts and sign-extends
//  the I/S/B/J/U immediate and the CSR zimm to XLEN bits, and reports the format code and an

---
 rtl/imm_gen_pipe_pkg.sv | 35 +++
 rtl/imm_decode.sv | 83 ++++++++
 rtl/imm_gen_pipe.sv | 105 ++++++++++
 tb/tb_imm_gen_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared encodings for the decode-stage immediate generator: opcodes, format codes and
// the funct3 bit that selects the CSR immediate form.
package imm_gen_pipe_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_J = 3'd3,
    FMT_U = 3'd4,
    FMT_Z = 3'd5,
    FMT_R = 3'd6
  } imm_fmt_e;

  // funct3 occupies instr[14:12]; bit 2 of funct3 marks the CSR-immediate variants
  localparam int FUNCT3_CSR_IMM_BIT = 2;
  localparam int FUNCT3_LSB         = 12;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32 immediate decoder: instr -> {imm, fmt, illegal}, extended to XLEN bits.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_EN = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]  opcode_s;
  logic [31:0] imm32_s;
  imm_fmt_e    fmt_s;
  logic        zext_s;
  logic        csr_imm_s;

  assign opcode_s  = instr[6:0];
  assign csr_imm_s = (CSR_EN != 0) && instr[FUNCT3_LSB + FUNCT3_CSR_IMM_BIT];

  // Select the immediate layout from the opcode; a 32-bit value is built first, then widened
  always_comb begin
    imm32_s = sext12(instr[31:20]);
    fmt_s   = FMT_I;
    zext_s  = 1'b0;
    illegal = 1'b0;
    case (opcode_s)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
        imm32_s = sext12(instr[31:20]);
        fmt_s   = FMT_I;
      end
      OPC_SYSTEM: begin
        if (csr_imm_s) begin
          imm32_s = {27'd0, instr[19:15]};
          fmt_s   = FMT_Z;
          zext_s  = 1'b1;
        end else begin
          imm32_s = sext12(instr[31:20]);
          fmt_s   = FMT_I;
        end
      end
      OPC_STORE: begin
        imm32_s = sext12({instr[31:25], instr[11:7]});
        fmt_s   = FMT_S;
      end
      OPC_BRANCH: begin
        imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt_s   = FMT_B;
      end
      OPC_JAL: begin
        imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt_s   = FMT_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32_s = {instr[31:12], 12'd0};
        fmt_s   = FMT_U;
      end
      OPC_OP: begin
        imm32_s = 32'd0;
        fmt_s   = FMT_R;
      end
      default: begin
        imm32_s = sext12(instr[31:20]);
        fmt_s   = FMT_I;
        illegal = 1'b1;
      end
    endcase
  end

  // Only the CSR zimm is zero-extended; everything else fills from bit 31
  always_comb begin
    if (zext_s) begin
      imm = XLEN'(imm32_s);
    end else begin
      imm = XLEN'($signed(imm32_s));
    end
  end

  assign fmt = fmt_s;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and an optional 1-entry skid
// buffer so a stalled EX stage never loses an instruction.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SKID_EN = 1,
  parameter int CSR_EN  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam int PW = XLEN + 4;

  logic [XLEN-1:0] dec_imm_s;
  logic [2:0]      dec_fmt_s;
  logic            dec_illegal_s;
  logic [PW-1:0]   dec_s;
  logic [PW-1:0]   out_r;
  logic [PW-1:0]   skid_r;
  logic            out_valid_r;
  logic            skid_valid_r;
  logic            in_ready_s;
  logic            accept_s;
  logic            out_free_s;

  imm_decode #(
    .XLEN   (XLEN),
    .CSR_EN (CSR_EN)
  ) u_decode (
    .instr   (instr),
    .imm     (dec_imm_s),
    .fmt     (dec_fmt_s),
    .illegal (dec_illegal_s)
  );

  assign dec_s = {dec_imm_s, dec_fmt_s, dec_illegal_s};

  // Without the skid entry, accepts are only possible when the output register is free
  always_comb begin
    if (SKID_EN != 0) begin
      in_ready_s = ~skid_valid_r;
    end else begin
      in_ready_s = out_ready | ~out_valid_r;
    end
  end

  assign accept_s   = in_valid & in_ready_s;
  assign out_free_s = ~out_valid_r | out_ready;

  // Valid bits: flush beats every handshake; a full skid entry has priority over new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        out_valid_r <= accept_s;
      end
    end else if (accept_s && (SKID_EN != 0)) begin
      skid_valid_r <= 1'b1;
    end
  end

  // Payload registers hold their last value when idle or flushed, so outputs never go X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r  <= '0;
      skid_r <= '0;
    end else if (!flush) begin
      if (out_free_s) begin
        if (skid_valid_r) begin
          out_r <= skid_r;
        end else if (accept_s) begin
          out_r <= dec_s;
        end
      end else if (accept_s) begin
        skid_r <= dec_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign imm       = out_r[PW-1:4];
  assign fmt       = out_r[3:1];
  assign illegal   = out_r[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: default instance (XLEN=32, skid, CSR) plus an
// XLEN=64 / CSR_EN=0 / no-skid instance for the wide and non-CSR decode cases.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        illegal;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] instr64 = 32'd0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        illegal64;

  exp_t exp_cur = '0;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic stall_prev = 1'b0;
  logic [35:0] held = '0;

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1), .CSR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .fmt(fmt),
    .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(0), .CSR_EN(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid64), .in_ready(in_ready64),
    .instr(instr64), .out_valid(out_valid64), .out_ready(out_ready64), .imm(imm64),
    .fmt(fmt64), .illegal(illegal64)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference decode for XLEN=32, CSR_EN=1
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e.ill = 1'b0;
    e.fmt = 3'd0;
    e.imm = {{20{i[31]}}, i[31:20]};
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: ;
      7'h73: if (i[14]) begin e.fmt = 3'd5; e.imm = {27'd0, i[19:15]}; end
      7'h23: begin e.fmt = 3'd1; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h63: begin e.fmt = 3'd2; e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
      7'h6F: begin e.fmt = 3'd3; e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = {i[31:12], 12'd0}; end
      7'h33: begin e.fmt = 3'd6; e.imm = 32'd0; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: pop on output handshake, push on input handshake, and check stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else if (flush) begin
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check_eq("stall_hold", {28'd0, imm, fmt, illegal}, {28'd0, held});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("imm", {32'd0, imm}, {32'd0, e.imm});
          check_eq("fmt", {61'd0, fmt}, {61'd0, e.fmt});
          check_eq("illegal", {63'd0, illegal}, {63'd0, e.ill});
        end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_cur);
      stall_prev = out_valid && !out_ready;
      held = {imm, fmt, illegal};
    end
  end

  task automatic send(input logic [31:0] i, input exp_t e);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    instr = i; exp_cur = e; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("send_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] v, input logic [2:0] f, input logic il);
    exp_t e;
    e.imm = v; e.fmt = f; e.ill = il;
    return e;
  endfunction

  task automatic send64(input logic [31:0] i);
    @(posedge clk); #1;
    instr64 = i; in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
  endtask

  logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h6F,
                            7'h37, 7'h17, 7'h33, 7'h5B};
  logic [31:0] rnd;
  logic        took;
  int          sent;

  initial begin
    #12;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_imm", {32'd0, imm}, 64'd0);
    check_eq("rst_fmt", {61'd0, fmt}, 64'd0);
    check_eq("rst_illegal", {63'd0, illegal}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;

    // Directed formats with the output always ready
    send(32'hFFF00093, mk(32'hFFFFFFFF, 3'd0, 1'b0));
    check_eq("lat_valid", {63'd0, out_valid}, 64'd1);
    check_eq("lat_imm", {32'd0, imm}, 64'h0000_0000_FFFF_FFFF);
    send(32'h80000063, mk(32'hFFFFF000, 3'd2, 1'b0));
    send(32'h800000EF, mk(32'hFFF00000, 3'd3, 1'b0));
    send(32'h123450B7, mk(32'h12345000, 3'd4, 1'b0));
    send(32'hFE112E23, mk(32'hFFFFFFFC, 3'd1, 1'b0));
    send(32'h3401D073, mk(32'h00000003, 3'd5, 1'b0));
    send(32'h002081B3, mk(32'h00000000, 3'd6, 1'b0));
    send(32'hFFF00000, mk(32'hFFFFFFFF, 3'd0, 1'b1));
    wait_drain();

    // Wide instance: sign fill for U and CSR treated as I-type
    send64(32'h800000B7);
    check_eq("x64_lui_valid", {63'd0, out_valid64}, 64'd1);
    check_eq("x64_lui_imm", imm64, 64'hFFFFFFFF80000000);
    send64(32'h3401D073);
    check_eq("x64_csr_imm", imm64, 64'h340);
    check_eq("x64_csr_fmt", {61'd0, fmt64}, 64'd0);
    check_eq("x64_csr_ill", {63'd0, illegal64}, 64'd0);

    // Stall: A on output, B in skid, C waits until the skid drains
    out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; instr = 32'h00500093; exp_cur = model(32'h00500093);
    @(posedge clk); #1; instr = 32'hABCDE0B7; exp_cur = model(32'hABCDE0B7);
    @(posedge clk); #1; instr = 32'hFE112E23; exp_cur = model(32'hFE112E23);
    check_eq("skid_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("skid_out_valid", {63'd0, out_valid}, 64'd1);
    check_eq("skid_head", {32'd0, imm}, 64'd5);
    repeat (2) begin @(posedge clk); #1; end
    check_eq("skid_still_full", {63'd0, in_ready}, 64'd0);
    check_eq("sb_depth", 64'(sb_q.size()), 64'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    check_eq("no_dup", {63'd0, out_valid}, 64'd0);

    // Flush with output and skid both full; the flush-cycle input is dropped
    out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; instr = 32'h00100013; exp_cur = model(32'h00100013);
    @(posedge clk); #1; instr = 32'h00200013; exp_cur = model(32'h00200013);
    @(posedge clk); #1; instr = 32'h00300013; exp_cur = model(32'h00300013); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(32'h7FF00013, mk(32'h000007FF, 3'd0, 1'b0));
    wait_drain();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; instr = 32'hFFF00093; exp_cur = model(32'hFFF00093);
    @(posedge clk); #1; instr = 32'h80000063; exp_cur = model(32'h80000063);
    @(posedge clk); #1; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst_imm", {32'd0, imm}, 64'd0);
    check_eq("arst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h123450B7, mk(32'h12345000, 3'd4, 1'b0));
    wait_drain();

    // Random stream with random downstream back-pressure
    sent = 0;
    for (int c = 0; c < 2000 && sent < 60; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (took) sent++;
      if (!in_valid || took) begin
        if (sent < 60 && $urandom_range(0, 3) != 0) begin
          rnd = $urandom();
          instr = {rnd[31:7], ops[$urandom_range(0, 11)]};
          exp_cur = model(instr);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check_eq("rand_sent", 64'(sent), 64'd60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
